// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Imported by the storage/scoreboard top and the read-port slices.
package regfile_pkg;

  localparam int REG_SZ_DEF  = 32;
  localparam int REG_NUM_DEF = 32;
  localparam int IDX_W_DEF   = $clog2(REG_NUM_DEF);
  localparam int ZERO_IDX    = 0;

  typedef logic [REG_SZ_DEF-1:0] word_t;
  typedef logic [IDX_W_DEF-1:0]  idx_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: serviceability test, write bypass mux,
// and the registered ack/data pair.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int REG_SZ = REG_SZ_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rreq,
  input  logic [IDX_W-1:0]  i_ridx,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [REG_SZ-1:0] i_wdata,
  input  logic              i_pend,
  input  logic [REG_SZ-1:0] i_reg,
  output logic              o_rack,
  output logic [REG_SZ-1:0] o_rdata
);

  localparam logic [IDX_W-1:0] ZIDX = IDX_W'(ZERO_IDX);

  logic              w_zero;
  logic              w_byp;
  logic              w_serv;
  logic [REG_SZ-1:0] w_val;
  logic              r_rack;
  logic [REG_SZ-1:0] r_rdata;

  assign w_zero = (i_ridx == ZIDX);
  // Bypass only matters for nonzero indices; keeps the mux one-hot.
  assign w_byp  = i_we && (i_widx == i_ridx) && !w_zero;
  assign w_serv = i_rreq && (w_zero || !i_pend || w_byp);

  always_comb begin
    w_val = i_reg;
    unique case (1'b1)
      w_zero:  w_val = '0;
      w_byp:   w_val = i_wdata;
      default: w_val = i_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rack  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rack <= w_serv;
      if (w_serv) begin
        r_rdata <= w_val;
      end
    end
  end

  assign o_rack  = r_rack;
  assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass, hardwired x0
// and a per-register pending scoreboard that stalls early reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int   REG_SZ   = REG_SZ_DEF,
  parameter int   REG_NUM  = REG_NUM_DEF,
  parameter int   RD_PORTS = 2,
  localparam int  IDX_W    = $clog2(REG_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RD_PORTS-1:0]        rreq,
  input  logic [RD_PORTS*IDX_W-1:0]  ridx,
  output logic [RD_PORTS-1:0]        rack,
  output logic [RD_PORTS*REG_SZ-1:0] rdata,
  input  logic                       we,
  input  logic [IDX_W-1:0]           widx,
  input  logic [REG_SZ-1:0]          wdata,
  output logic                       wack,
  input  logic                       resv,
  input  logic [IDX_W-1:0]           resv_idx,
  output logic [REG_NUM-1:0]         pend
);

  localparam logic [IDX_W-1:0] ZIDX = IDX_W'(ZERO_IDX);

  logic [REG_SZ-1:0]  r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_pend;
  logic [REG_NUM-1:0] w_pend_nx;
  logic               r_wack;
  logic               w_wr;
  logic               w_rs;

  assign w_wr = we && (widx != ZIDX);
  assign w_rs = resv && (resv_idx != ZIDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < REG_NUM; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr) begin
      r_regs[widx] <= wdata;
    end
  end

  // Reserve is applied after the clear: a new producer wins.
  always_comb begin
    w_pend_nx = r_pend;
    if (w_wr) begin
      w_pend_nx[widx] = 1'b0;
    end
    if (w_rs) begin
      w_pend_nx[resv_idx] = 1'b1;
    end
    w_pend_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_wack <= 1'b0;
    end else begin
      r_pend <= w_pend_nx;
      r_wack <= we;
    end
  end

  assign pend = r_pend;
  assign wack = r_wack;

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
    logic [IDX_W-1:0] w_ridx;
    assign w_ridx = ridx[g*IDX_W +: IDX_W];

    regfile_rd_port #(
      .REG_SZ (REG_SZ),
      .IDX_W  (IDX_W)
    ) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_rreq  (rreq[g]),
      .i_ridx  (w_ridx),
      .i_we    (we),
      .i_widx  (widx),
      .i_wdata (wdata),
      .i_pend  (r_pend[w_ridx]),
      .i_reg   (r_regs[w_ridx]),
      .o_rack  (rack[g]),
      .o_rdata (rdata[g*REG_SZ +: REG_SZ])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table, mid-cycle reset sequence and random
// traffic checked against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int NP = 2;
  localparam int IW = IDX_W_DEF;
  localparam int RN = REG_NUM_DEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    rreq;
  logic [NP*IW-1:0] ridx;
  logic [NP-1:0]    rack;
  logic [NP*32-1:0] rdata;
  logic             we;
  idx_t             widx;
  word_t            wdata;
  logic             wack;
  logic             resv;
  idx_t             resv_idx;
  logic [RN-1:0]    pend;

  int checks = 0;
  int errors = 0;

  word_t         m_regs [RN];
  bit            m_pend [RN];
  logic [NP-1:0] m_rack;
  word_t         m_rdata [NP];
  logic          m_wack;

  typedef struct {
    bit        we;
    int        widx;
    word_t     wdata;
    bit        resv;
    int        ridx_r;
    bit [1:0]  rq;
    int        ri0;
    int        ri1;
    bit [1:0]  e_rack;
    bit        e_wack;
    word_t     e_rd0;
    word_t     e_rd1;
    int        p_idx;
    bit        p_val;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  regfile_sb #(.RD_PORTS(NP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rreq     (rreq),
    .ridx     (ridx),
    .rack     (rack),
    .rdata    (rdata),
    .we       (we),
    .widx     (widx),
    .wdata    (wdata),
    .wack     (wack),
    .resv     (resv),
    .resv_idx (resv_idx),
    .pend     (pend)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, int wi, word_t wd, bit rs,
                              int rsi, bit [1:0] rq, int r0, int r1,
                              bit [1:0] ea, bit ew, word_t d0,
                              word_t d1, int pi, bit pv);
    vec_t v;
    v.we = w; v.widx = wi; v.wdata = wd; v.resv = rs;
    v.ridx_r = rsi; v.rq = rq; v.ri0 = r0; v.ri1 = r1;
    v.e_rack = ea; v.e_wack = ew; v.e_rd0 = d0; v.e_rd1 = d1;
    v.p_idx = pi; v.p_val = pv;
    return v;
  endfunction

  task automatic idle();
    rreq = '0; ridx = '0; we = 1'b0; widx = '0;
    wdata = '0; resv = 1'b0; resv_idx = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < RN; k++) begin
      m_regs[k] = '0;
      m_pend[k] = 1'b0;
    end
    for (int p = 0; p < NP; p++) m_rdata[p] = '0;
    m_rack = '0;
    m_wack = 1'b0;
  endtask

  // Applies one clock worth of the architectural rules to the model.
  task automatic model_edge();
    for (int p = 0; p < NP; p++) begin
      int  i;
      bit  byp;
      i   = int'(ridx[p*IW +: IW]);
      byp = we && (int'(widx) == i);
      m_rack[p] = 1'b0;
      if (rreq[p] && (i == 0 || !m_pend[i] || byp)) begin
        m_rack[p] = 1'b1;
        if (i == 0)   m_rdata[p] = '0;
        else if (byp) m_rdata[p] = wdata;
        else          m_rdata[p] = m_regs[i];
      end
    end
    m_wack = we;
    if (we && widx != 0) begin
      m_regs[widx] = wdata;
      m_pend[widx] = 1'b0;
    end
    if (resv && resv_idx != 0) m_pend[resv_idx] = 1'b1;
  endtask

  task automatic model_cmp(input string tag);
    logic [RN-1:0] pv;
    for (int k = 0; k < RN; k++) pv[k] = m_pend[k];
    chk({tag, ".rack"}, 32'(rack), 32'(m_rack));
    chk({tag, ".wack"}, 32'(wack), 32'(m_wack));
    chk({tag, ".rd0"}, rdata[31:0], m_rdata[0]);
    chk({tag, ".rd1"}, rdata[63:32], m_rdata[1]);
    chk({tag, ".pend"}, 32'(pend), 32'(pv));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    model_cmp(tag);
  endtask

  initial begin
    idle();
    model_reset();

    tbl[0]  = mk(0, 0, 0, 0, 0, 2'b01, 5, 0,
                 2'b01, 0, 0, 0, 5, 0);
    tbl[1]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0,
                 2'b00, 1, 0, 0, 3, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 2'b01, 3, 0,
                 2'b01, 0, 32'hDEADBEEF, 0, 3, 0);
    tbl[3]  = mk(1, 0, 32'h1234, 0, 0, 2'b00, 0, 0,
                 2'b00, 1, 32'hDEADBEEF, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 2'b01, 0, 0,
                 2'b01, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 7, 2'b00, 0, 0,
                 2'b00, 0, 0, 0, 7, 1);
    for (int r = 6; r < 10; r++)
      tbl[r] = mk(0, 0, 0, 0, 0, 2'b10, 0, 7,
                  2'b00, 0, 0, 0, 7, 1);
    tbl[10] = mk(1, 7, 32'h55, 0, 0, 2'b10, 0, 7,
                 2'b10, 1, 0, 32'h55, 7, 0);
    tbl[11] = mk(1, 9, 32'hAA, 1, 9, 2'b01, 9, 0,
                 2'b01, 1, 32'hAA, 32'h55, 9, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 2'b10, 0, 9,
                 2'b00, 0, 32'hAA, 32'h55, 9, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.rack", 32'(rack), 0);
    chk("rst.wack", 32'(wack), 0);
    chk("rst.pend", 32'(pend), 0);
    chk("rst.rdata", rdata[31:0] | rdata[63:32], 0);
    #2 rst_n = 1'b1;

    for (int r = 0; r < 13; r++) begin
      string t;
      t = $sformatf("vec%0d", r);
      we = tbl[r].we; widx = idx_t'(tbl[r].widx);
      wdata = tbl[r].wdata; resv = tbl[r].resv;
      resv_idx = idx_t'(tbl[r].ridx_r); rreq = tbl[r].rq;
      ridx[IW-1:0] = idx_t'(tbl[r].ri0);
      ridx[2*IW-1:IW] = idx_t'(tbl[r].ri1);
      step(t);
      chk({t, ".xrack"}, 32'(rack), 32'(tbl[r].e_rack));
      chk({t, ".xwack"}, 32'(wack), 32'(tbl[r].e_wack));
      chk({t, ".xrd0"}, rdata[31:0], tbl[r].e_rd0);
      chk({t, ".xrd1"}, rdata[63:32], tbl[r].e_rd1);
      chk({t, ".xpend"}, 32'(pend[tbl[r].p_idx]),
          32'(tbl[r].p_val));
    end

    // Stalled read on a reserved register, then async reset mid-cycle.
    idle();
    resv = 1'b1; resv_idx = 5'd4;
    step("mr.resv");
    idle();
    rreq = 2'b01; ridx[IW-1:0] = 5'd4;
    we = 1'b1; widx = 5'd2; wdata = 32'h77;
    step("mr.stall");
    chk("mr.pre_wack", 32'(wack), 1);
    chk("mr.pre_pend4", 32'(pend[4]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.rack", 32'(rack), 0);
    chk("mr.wack", 32'(wack), 0);
    chk("mr.pend", 32'(pend), 0);
    chk("mr.rdata", rdata[31:0] | rdata[63:32], 0);
    model_reset();
    idle();
    @(posedge clk);
    #2 rst_n = 1'b1;
    rreq = 2'b01; ridx[IW-1:0] = 5'd4;
    step("mr.after");
    chk("mr.after_rack", 32'(rack[0]), 1);
    chk("mr.after_rd0", rdata[31:0], 0);

    for (int c = 0; c < 400; c++) begin
      we = ($urandom_range(1) == 1);
      widx = idx_t'($urandom_range(7));
      wdata = $urandom;
      resv = ($urandom_range(3) == 0);
      resv_idx = idx_t'($urandom_range(7));
      for (int p = 0; p < NP; p++) begin
        rreq[p] = ($urandom_range(3) != 0);
        ridx[p*IW +: IW] = idx_t'($urandom_range(7));
      end
      step($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-port register file.
- Provides RD_PORTS independent read ports and one write port, each with a registered req/ack handshake.
- Adds write-to-read bypass, a hardwired-zero register 0, and a per-register pending (scoreboard) bit that stalls reads of registers still awaiting a producer.
- Sits between decode/issue (reads, reservations) and writeback (writes) in the RISCV32 core.

Parameters:
- REG_SZ, 32, data width of each register.
- REG_NUM, 32, number of registers; must be a power of two, at least 2.
- IDX_W, $clog2(REG_NUM), width of register index; derived, not overridden.
- RD_PORTS, 2, number of read ports, 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rreq  in  RD_PORTS  read request per port; level, held until rack.
- ridx  in  RD_PORTS*IDX_W  read index per port; port i at bits [i*IDX_W +: IDX_W].
- rack  out  RD_PORTS  read acknowledge; one-cycle pulse per port.
- rdata  out  RD_PORTS*REG_SZ  read data per port; valid in the rack cycle, held afterwards.
- we  in  1  write request; single-cycle strobe.
- widx  in  IDX_W  write index.
- wdata  in  REG_SZ  write data.
- wack  out  1  write acknowledge; pulses one cycle after we.
- resv  in  1  reserve strobe; marks resv_idx pending.
- resv_idx  in  IDX_W  register to reserve.
- pend  out  REG_NUM  pending bit vector; pend[0] is always 0.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, pend 0, rack 0, wack 0, rdata 0. Any in-flight request is dropped; requesters re-issue after reset.
- Register 0:
  - Reads of register 0 always return 0.
  - Writes to register 0 are discarded but still acked.
  - Reserves of register 0 are ignored.
- Write:
  - On a cycle with we=1, regs[widx]<=wdata (except index 0) and pend[widx]<=0.
  - wack=1 in the next cycle only. Back-to-back writes give back-to-back wack.
- Reserve:
  - On a cycle with resv=1, pend[resv_idx]<=1.
  - If we and resv target the same index in the same cycle, the data is written and pend stays 1: the reserve wins and represents a new producer.
- Read port i, serviceable in cycle t when rreq[i]=1 and any of:
  - ridx[i]==0, or
  - pend[ridx[i]]==0, or
  - we=1 with widx==ridx[i] (bypass).
- Read port i, response when serviceable: in cycle t+1, rack[i]=1 and rdata[i] = the value chosen in cycle t:
  - 0 if ridx==0;
  - else wdata if bypassing;
  - else regs[ridx].
- Read port i, when not serviceable: rack[i]=0 and rdata[i] holds its last value. The request stalls until the register's write arrives, and is then served by the bypass rule in that same cycle.
- Repeated reads: a port with rreq held high after rack is served again, one rack per serviceable cycle. Requesters drop rreq in the rack cycle or accept duplicate acks.
- Read latency: 1 cycle when not pending; 1 cycle after the resolving write otherwise.
- Ports are independent: all RD_PORTS may read the same index in the same cycle, and each acks separately.
- Read and reserve of the same index in the same cycle: the read sees the pre-reserve pend value and is served if that bit was 0.
- No combinational path from any input to rack, wack, or rdata; all outputs are registered.
- pend output is the registered scoreboard value.

Decomposition:
- Shared package regfile_pkg:
  - REG_SZ_DEF = 32, REG_NUM_DEF = 32, and the derived index width.
  - ZERO_IDX = 0.
  - A word type logic [REG_SZ_DEF-1:0] and an index type.
- Sub-module regfile_rd_port, instantiated RD_PORTS times via generate. Per port it contains:
  - the serviceable test and bypass mux;
  - the rack and rdata registers.
- The top level owns the storage array, the pend vector, and the wack register.

Test Plan:
- Reset then read: rst_n low then high; ridx0=5, rreq0=1 for one cycle -> rack0 pulses in the next cycle with rdata0=0; pend all 0.
- Write then read: we with widx=3, wdata=0xDEADBEEF -> wack next cycle. Next cycle rreq0 with ridx0=3 -> rdata0=0xDEADBEEF with rack0.
- Register 0 write: we with widx=0, wdata=0x1234 -> wack=1; a later read of index 0 returns 0.
- Scoreboard stall: resv with idx 7 -> pend[7]=1. rreq1 with ridx1=7 held for 4 cycles -> rack1=0 throughout. Then we with widx=7, wdata=0x55 -> rack1=1 next cycle, rdata1=0x55, pend[7]=0.
- Simultaneous events, all in one cycle: we and resv both on idx 9 with wdata=0xAA, and port0 reading idx 9 -> rdata0=0xAA with rack0 next cycle, pend[9]=1, regs[9]=0xAA.
- Mid-operation reset: pend[4]=1 with a stalled read on port 0, then rst_n pulsed low asynchronously mid-cycle -> rack and wack 0 immediately, pend=0, rdata=0; after release, a read of idx 4 returns 0.
